// File: rtl/fft_out_capture.sv
// fft_out_capture
//   Captures one output frame of the streaming FFT core and replays it as a
//   word stream. A frame starts on the cycle after next_out is sampled. It
//   consists of FRAME_CYCLES lines of LANES words, each WIDTH bits wide. The
//   frame is read back line-major and lane-minor: index = line*LANES + lane.
//
//   Optional build macro: FFT_CAP_PINGPONG_EN. When it is defined there are
//   two frame banks, so a capture can run while the other bank drains. The
//   default build has a single bank.
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   next_out   frame-start strobe from the FFT core
//   y_in       packed core outputs; lane k is at bits [k*WIDTH +: WIDTH]
//   rd_valid   rd_data/rd_index/rd_last hold a valid word
//   rd_ready   consumer accepts the word
//   rd_data    current word
//   rd_index   word index within the frame
//   rd_last    marks word FRAME_WORDS-1
//   busy       high whenever the block is not idle
//   ovf        sticky: a frame was dropped because no bank was free
//   proto_err  sticky: next_out was seen while a capture was in progress
//   dbg_state  current state (IDLE=0, CAPTURE=1, DRAIN=2)
//
// Read handshake: a word transfers on every rising edge where rd_valid and
//   rd_ready are both high. While rd_valid is high and rd_ready is low,
//   rd_data, rd_index and rd_last hold their values. rd_valid does not depend
//   on rd_ready.
//
// LANES and FRAME_CYCLES must be powers of two, and each must be at least 2.
module fft_out_capture #(
  parameter int WIDTH        = 64,
  parameter int LANES        = 16,
  parameter int FRAME_CYCLES = 64,
  localparam int FRAME_WORDS = LANES * FRAME_CYCLES,
  localparam int IDXW        = $clog2(FRAME_WORDS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   next_out,
  input  logic [LANES*WIDTH-1:0] y_in,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [WIDTH-1:0]       rd_data,
  output logic [IDXW-1:0]        rd_index,
  output logic                   rd_last,
  output logic                   busy,
  output logic                   ovf,
  output logic                   proto_err,
  output logic [1:0]             dbg_state
);
  localparam int LANEW = $clog2(LANES);
  localparam int LINEW = $clog2(FRAME_CYCLES);
`ifdef FFT_CAP_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam int AW = $clog2(NB * FRAME_CYCLES);

  typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, DRAIN = 2'd2} state_t;
  state_t state, state_n;

  // Frame storage: bank b, line j is stored at address b*FRAME_CYCLES + j.
  logic [LANES*WIDTH-1:0] mem [NB*FRAME_CYCLES];

  logic             cap_on, cap_on_n, cap_bank, cap_bank_n;
  logic [LINEW-1:0] line_cnt, line_n;
  logic [NB-1:0]    used, used_n;       // bank is capturing, full, or draining
  logic             pend_valid, pend_valid_n, pend_bank, pend_bank_n;
  logic             rd_bank, rd_bank_n;
  logic             rd_valid_n, rd_last_n, ovf_n, perr_n;
  logic [IDXW-1:0]  rd_index_n, sel_idx;
  logic [WIDTH-1:0] rd_data_n, rd_word;
  logic             xfer, last_xfer, cap_done;
  logic             free_ok, free_bank, start_ok, start_bank, sel_bank;

  function automatic logic [AW-1:0] addr_of(input logic bank, input logic [LINEW-1:0] line);
    return (bank ? AW'(FRAME_CYCLES) : AW'(0)) + AW'(line);
  endfunction

  assign xfer      = rd_valid && rd_ready;
  assign last_xfer = xfer && rd_last;
  assign cap_done  = cap_on && (line_cnt == LINEW'(FRAME_CYCLES - 1));
  assign dbg_state = state;

  // A bank whose last word transfers this cycle counts as free. This lets a
  // new frame be accepted on the same cycle that the previous drain ends.
  always_comb begin
    free_ok   = 1'b0;
    free_bank = 1'b0;
    for (int b = NB - 1; b >= 0; b--) begin
      if (!used[b] || (last_xfer && (rd_bank == 1'(b)))) begin
        free_ok   = 1'b1;
        free_bank = 1'(b);
      end
    end
  end

  // A new drain starts when the read port is idle or finishing. A bank that
  // is already waiting goes first, which keeps frames in arrival order.
  // The word for the next cycle is read from the register file here, one
  // cycle ahead, so drains run back-to-back without a bubble.
  always_comb begin
    start_ok   = 1'b0;
    start_bank = 1'b0;
    if (!rd_valid || last_xfer) begin
      if (pend_valid) begin
        start_ok   = 1'b1;
        start_bank = pend_bank;
      end else if (cap_done) begin
        start_ok   = 1'b1;
        start_bank = cap_bank;
      end
    end
    sel_bank = start_ok ? start_bank : rd_bank;
    sel_idx  = start_ok ? '0 : rd_index + 1'b1;
  end

  assign rd_word = mem[addr_of(sel_bank, sel_idx[IDXW-1:LANEW])]
                      [int'(sel_idx[LANEW-1:0]) * WIDTH +: WIDTH];

  always_comb begin
    cap_on_n     = cap_on;
    cap_bank_n   = cap_bank;
    line_n       = line_cnt;
    used_n       = used;
    pend_valid_n = pend_valid;
    pend_bank_n  = pend_bank;
    rd_valid_n   = rd_valid;
    rd_bank_n    = rd_bank;
    rd_index_n   = rd_index;
    rd_data_n    = rd_data;
    rd_last_n    = rd_last;
    ovf_n        = ovf;
    perr_n       = proto_err;

    if (last_xfer) used_n[rd_bank] = 1'b0;

    if (cap_on) begin
      line_n = line_cnt + 1'b1;
      if (cap_done) cap_on_n = 1'b0;
      if (next_out) perr_n = 1'b1;
    end else if (next_out) begin
      if (free_ok) begin
        cap_on_n         = 1'b1;
        cap_bank_n       = free_bank;
        line_n           = '0;
        used_n[free_bank] = 1'b1;
      end else begin
        ovf_n = 1'b1;
      end
    end

    if (start_ok && pend_valid) pend_valid_n = 1'b0;
    // A completed capture waits unless it went straight onto the read port.
    if (cap_done && !(start_ok && !pend_valid)) begin
      pend_valid_n = 1'b1;
      pend_bank_n  = cap_bank;
    end

    if (start_ok) begin
      rd_valid_n = 1'b1;
      rd_bank_n  = start_bank;
      rd_index_n = '0;
      rd_data_n  = rd_word;
      rd_last_n  = (FRAME_WORDS == 1);
    end else if (last_xfer) begin
      rd_valid_n = 1'b0;
    end else if (xfer) begin
      rd_index_n = sel_idx;
      rd_data_n  = rd_word;
      rd_last_n  = (sel_idx == IDXW'(FRAME_WORDS - 1));
    end

    if (cap_on_n)                       state_n = CAPTURE;
    else if (rd_valid_n || pend_valid_n) state_n = DRAIN;
    else                                state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      cap_on     <= 1'b0;
      cap_bank   <= 1'b0;
      line_cnt   <= '0;
      used       <= '0;
      pend_valid <= 1'b0;
      pend_bank  <= 1'b0;
      rd_valid   <= 1'b0;
      rd_bank    <= 1'b0;
      rd_index   <= '0;
      rd_data    <= '0;
      rd_last    <= 1'b0;
      ovf        <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      state      <= state_n;
      busy       <= (state_n != IDLE);
      cap_on     <= cap_on_n;
      cap_bank   <= cap_bank_n;
      line_cnt   <= line_n;
      used       <= used_n;
      pend_valid <= pend_valid_n;
      pend_bank  <= pend_bank_n;
      rd_valid   <= rd_valid_n;
      rd_bank    <= rd_bank_n;
      rd_index   <= rd_index_n;
      rd_data    <= rd_data_n;
      rd_last    <= rd_last_n;
      ovf        <= ovf_n;
      proto_err  <= perr_n;
    end
  end

  // Storage has no reset. Stale contents are never presented, because the
  // bank-usage flags clear on reset.
  always_ff @(posedge clk) begin
    if (cap_on) mem[addr_of(cap_bank, line_cnt)] <= y_in;
  end
endmodule
